split_slave_port: RTL and testbench
===================================

// Module: split_slave_port
// PURPOSE
// Parametrised bit-serial bus slave port with split-transaction reads, between the bus interconnect and a slave memory.
// Deserialises address and write data from the bus and issues single-cycle memory read/write strobes.
// For reads, releases the bus (split) for a programmable latency, then serialises read data back to the master.
// Replaces the fixed 12/8-bit slave port; widths and split latency are now generics, and rx/tx stall on handshakes.
// PARAMETERS
// ADDR_WIDTH     12  address bits received serially, LSB first
// DATA_WIDTH     8   data bits received/transmitted serially, LSB first
// SPLIT_LATENCY  4   cycles split_en is held after mem_rd (0 = no split phase)
// PORTS
// clk           in   1           system clock, all state on rising edge
// reset         in   1           asynchronous, active-low reset
// read_en       in   1           read request from bus controller (sampled in IDLE only)
// write_en      in   1           write request from bus controller (sampled in IDLE only)
// master_valid  in   1           master drives a valid bit on rx_address/rx_data this cycle
// master_ready  in   1           master accepts tx_data bit this cycle
// rx_address    in   1           serial address bit
// rx_data       in   1           serial write-data bit
// datain        in   DATA_WIDTH  read data from memory
// slave_ready   out  1           port can accept request/rx bits (high in IDLE and RX)
// slave_valid   out  1           tx_data carries a valid read-data bit
// tx_data       out  1           serial read-data bit
// address       out  ADDR_WIDTH  assembled address, held until next transfer
// data          out  DATA_WIDTH  assembled write data, held until next transfer
// mem_wr        out  1           one-cycle memory write strobe
// mem_rd        out  1           one-cycle memory read strobe
// split_en      out  1           bus may be released to other masters
// rx_done       out  1           one-cycle pulse: last rx bit sampled
// tx_done       out  1           one-cycle pulse: last tx bit accepted
// BEHAVIOUR
// - Reset (async, reset=0): state IDLE, counters 0, request latches 0, all outputs 0 except slave_ready=1. Reset mid-op aborts silently.
// - States: IDLE, RX, WR, RD, SPLIT, TX.
// - IDLE: read_en/write_en latched; both high same cycle -> write wins, read dropped. Requests outside IDLE ignored.
// - IDLE->RX on first cycle with master_valid=1 and (latched req or req this cycle); that cycle's bits = bit 0.
// - RX: one bit sampled per cycle with master_valid=1; master_valid=0 stalls (no sample, counter held).
// - Address shifts for ADDR_WIDTH sampled cycles; data shifts for the first DATA_WIDTH sampled cycles (write only).
// - RX length: write = max(ADDR_WIDTH,DATA_WIDTH), read = ADDR_WIDTH. Counter width $clog2(max+1).
// - Last bit sampled in cycle N: rx_done=1 in N+1; address/data registers final from N+1.
// - Write: WR in N+1, mem_wr=1 for that cycle only, then IDLE.
// - Read: RD in N+1, mem_rd=1; SPLIT for SPLIT_LATENCY cycles (N+2..N+1+L), split_en=1 throughout.
// - datain captured at end of last SPLIT cycle (end of RD when L=0); memory must hold datain valid by then.
// - TX from cycle N+2+L: slave_valid=1, tx_data=bit 0; shift advances on each edge with master_ready=1.
// - master_ready=0 holds the current bit and slave_valid.
// - After bit DATA_WIDTH-1 accepted: next cycle IDLE, slave_valid=0, tx_data=0, tx_done=1 for one cycle.
// - slave_ready=0 in WR, RD, SPLIT, TX; master_valid there ignored. Request latch cleared on leaving RX.
// TESTING (ADDR_WIDTH=12, DATA_WIDTH=8, SPLIT_LATENCY=4 unless noted)
// 1 write_en pulse, 12 bits addr 0xA5C + 8 bits data 0x3B, master_valid=1 -> rx_done and mem_wr in cycle after 12th bit, address=0xA5C, data=0x3B.
// 2 read addr 0x123, datain=0xC6 -> mem_rd at N+1, split_en N+2..N+5, slave_valid N+6, tx_data 0,1,1,0,0,0,1,1, tx_done after 8th.
// 3 master_valid low 3 cycles after bit 5 of addr 0x7FF -> address=0x7FF, completion delayed exactly 3 cycles.
// 4 master_ready low 2 cycles during tx bit 3 -> bit 3 held 3 cycles, remaining bits correct, slave_valid stays 1.
// 5 read_en and write_en high same cycle -> write performed, mem_rd never asserted; SPLIT_LATENCY=0 read -> slave_valid at N+2.
// 6 reset=0 mid-SPLIT -> all outputs reset values immediately; next read after release completes normally.

Source files
------------

// File: rtl/split_slave_port_if.sv
// Bus-side handshake and serial signals between an interconnect master and split_slave_port.
interface split_slave_port_if;
  logic read_en;
  logic write_en;
  logic master_valid;
  logic master_ready;
  logic rx_address;
  logic rx_data;
  logic slave_ready;
  logic slave_valid;
  logic tx_data;
  logic split_en;
  logic rx_done;
  logic tx_done;

  modport slave (
    input  read_en, write_en, master_valid, master_ready, rx_address, rx_data,
    output slave_ready, slave_valid, tx_data, split_en, rx_done, tx_done
  );

  modport master (
    output read_en, write_en, master_valid, master_ready, rx_address, rx_data,
    input  slave_ready, slave_valid, tx_data, split_en, rx_done, tx_done
  );
endinterface

// File: rtl/split_slave_port.sv
// Bit-serial bus slave port: deserialises address/write data, strobes memory,
// releases the bus for a split phase on reads, then serialises read data back.
module split_slave_port #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int SPLIT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  split_slave_port_if.slave     bus,
  input  logic [DATA_WIDTH-1:0] datain,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  mem_wr,
  output logic                  mem_rd
);
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int SW   = (SPLIT_LATENCY > 1) ? $clog2(SPLIT_LATENCY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_RX, S_WR, S_RD, S_SPLIT, S_TX} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_wr_req, r_rd_req, r_is_wr, r_tx_done;
  logic [CW-1:0]         r_cnt;
  logic [SW-1:0]         r_scnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data, r_rdata;

  logic          w_wr_any, w_rd_any, w_req, w_sample, w_wr_sel, w_leave_rx;
  logic [CW-1:0] w_len_new, w_len_cur;
  logic          w_tx_last, w_split_last;

  assign w_wr_any     = r_wr_req | bus.write_en;
  assign w_rd_any     = r_rd_req | bus.read_en;
  assign w_req        = w_wr_any | w_rd_any;
  assign w_len_new    = w_wr_any ? CW'(MAXW) : CW'(ADDR_WIDTH);
  assign w_len_cur    = r_is_wr  ? CW'(MAXW) : CW'(ADDR_WIDTH);
  assign w_tx_last    = (r_cnt == CW'(DATA_WIDTH - 1));
  assign w_split_last = (r_scnt == SW'(SPLIT_LATENCY - 1));
  assign w_wr_sel     = (r_state == S_IDLE) ? w_wr_any : r_is_wr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sample        = 1'b0;
    bus.slave_ready = 1'b0;
    bus.slave_valid = 1'b0;
    bus.tx_data     = 1'b0;
    bus.split_en    = 1'b0;
    bus.rx_done     = 1'b0;
    bus.tx_done     = r_tx_done;
    mem_wr          = 1'b0;
    mem_rd          = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.slave_ready = 1'b1;
        if (bus.master_valid && w_req) begin
          w_sample = 1'b1;
          if (w_len_new == CW'(1)) w_state_nxt = w_wr_any ? S_WR : S_RD;
          else                     w_state_nxt = S_RX;
        end
      end
      S_RX: begin
        bus.slave_ready = 1'b1;
        if (bus.master_valid) begin
          w_sample = 1'b1;
          if (r_cnt == w_len_cur - CW'(1)) w_state_nxt = r_is_wr ? S_WR : S_RD;
        end
      end
      S_WR: begin
        bus.rx_done = 1'b1;
        mem_wr      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_RD: begin
        bus.rx_done = 1'b1;
        mem_rd      = 1'b1;
        w_state_nxt = (SPLIT_LATENCY == 0) ? S_TX : S_SPLIT;
      end
      S_SPLIT: begin
        bus.split_en = 1'b1;
        if (w_split_last) w_state_nxt = S_TX;
      end
      S_TX: begin
        bus.slave_valid = 1'b1;
        bus.tx_data     = r_rdata[0];
        if (bus.master_ready && w_tx_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_leave_rx = (r_state == S_IDLE || r_state == S_RX) &&
                      (w_state_nxt != S_IDLE && w_state_nxt != S_RX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_req  <= 1'b0;
      r_rd_req  <= 1'b0;
      r_is_wr   <= 1'b0;
      r_tx_done <= 1'b0;
      r_cnt     <= '0;
      r_scnt    <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_rdata   <= '0;
    end else begin
      r_tx_done <= (r_state == S_TX) && bus.master_ready && w_tx_last;
      // Write wins a same-cycle collision; the read request is dropped.
      if (r_state == S_IDLE) begin
        r_wr_req <= w_wr_any;
        r_rd_req <= w_rd_any & ~w_wr_any;
        if (w_sample) r_is_wr <= w_wr_any;
      end
      if (w_sample) begin
        if (r_cnt < CW'(ADDR_WIDTH)) r_addr <= {bus.rx_address, r_addr[ADDR_WIDTH-1:1]};
        if (w_wr_sel && r_cnt < CW'(DATA_WIDTH)) r_data <= {bus.rx_data, r_data[DATA_WIDTH-1:1]};
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_leave_rx) begin
        r_cnt    <= '0;
        r_wr_req <= 1'b0;
        r_rd_req <= 1'b0;
      end
      case (r_state)
        S_RD: begin
          r_scnt <= '0;
          if (SPLIT_LATENCY == 0) r_rdata <= datain;
        end
        S_SPLIT: begin
          r_scnt <= r_scnt + SW'(1);
          if (w_split_last) r_rdata <= datain;
        end
        S_TX: begin
          if (bus.master_ready) begin
            r_rdata <= r_rdata >> 1;
            r_cnt   <= w_tx_last ? '0 : r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign address = r_addr;
  assign data    = r_data;
endmodule

// File: tb/tb_split_slave_port.sv
// Directed bench for split_slave_port: a SPLIT_LATENCY=4 instance plus a
// SPLIT_LATENCY=0 instance driven by the same bus stimulus.
module tb_split_slave_port;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  datain = 8'h00;
  logic [11:0] addr4, addr0;
  logic [7:0]  data4, data0;
  logic        mw4, mr4, mw0, mr0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          t0;

  split_slave_port_if b4();
  split_slave_port_if b0();

  assign b0.read_en      = b4.read_en;
  assign b0.write_en     = b4.write_en;
  assign b0.master_valid = b4.master_valid;
  assign b0.master_ready = b4.master_ready;
  assign b0.rx_address   = b4.rx_address;
  assign b0.rx_data      = b4.rx_data;

  split_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_LATENCY(4)) u_dut (
    .clk(clk), .reset(reset), .bus(b4), .datain(datain),
    .address(addr4), .data(data4), .mem_wr(mw4), .mem_rd(mr4)
  );

  split_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .SPLIT_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(b0), .datain(datain),
    .address(addr0), .data(data0), .mem_wr(mw0), .mem_rd(mr0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Serialise 12 address bits (and 8 data bits); request pulsed with bit 0.
  task automatic send(input bit wr, input bit rd, input logic [11:0] a, input logic [7:0] d,
                      input int stall_at, input int stall_n);
    logic [11:0] dd;
    dd = {4'h0, d};
    for (int i = 0; i < 12; i++) begin
      b4.write_en     = (i == 0) && wr;
      b4.read_en      = (i == 0) && rd;
      b4.master_valid = 1'b1;
      b4.rx_address   = a[i];
      b4.rx_data      = dd[i];
      tick;
      if (i == stall_at) begin
        b4.master_valid = 1'b0;
        b4.write_en     = 1'b0;
        b4.read_en      = 1'b0;
        repeat (stall_n) tick;
      end
    end
    b4.master_valid = 1'b0;
    b4.write_en     = 1'b0;
    b4.read_en      = 1'b0;
    b4.rx_address   = 1'b0;
    b4.rx_data      = 1'b0;
  endtask

  // Called in the first TX cycle; optionally holds master_ready low at one bit.
  task automatic recv(input string tag, input logic [7:0] exp, input int hold_at, input int hold_n);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_sv"}, b4.slave_valid, 1);
      chk($sformatf("%s_bit%0d", tag, i), b4.tx_data, exp[i]);
      if (i == hold_at) begin
        b4.master_ready = 1'b0;
        repeat (hold_n) begin
          tick;
          chk({tag, "_hold_sv"}, b4.slave_valid, 1);
          chk({tag, "_hold_bit"}, b4.tx_data, exp[i]);
        end
        b4.master_ready = 1'b1;
      end
      tick;
    end
    chk({tag, "_tx_done"}, b4.tx_done, 1);
    chk({tag, "_sv_end"}, b4.slave_valid, 0);
    chk({tag, "_txd_end"}, b4.tx_data, 0);
    tick;
    chk({tag, "_tx_done_pulse"}, b4.tx_done, 0);
  endtask

  initial begin
    b4.read_en = 1'b0; b4.write_en = 1'b0; b4.master_valid = 1'b0;
    b4.master_ready = 1'b1; b4.rx_address = 1'b0; b4.rx_data = 1'b0;
    #2;
    chk("rst_slave_ready", b4.slave_ready, 1);
    chk("rst_slave_valid", b4.slave_valid, 0);
    chk("rst_split_en", b4.split_en, 0);
    chk("rst_mem", {mw4, mr4}, 0);
    chk("rst_addr", addr4, 0);
    chk("rst_done", {b4.rx_done, b4.tx_done}, 0);
    repeat (2) tick;
    reset = 1'b1;
    tick;

    // 1: write 0xA5C <- 0x3B
    t0 = cyc;
    send(1, 0, 12'hA5C, 8'h3B, -1, 0);
    chk("t1_latency", cyc - t0, 12);
    chk("t1_rx_done", b4.rx_done, 1);
    chk("t1_mem_wr", mw4, 1);
    chk("t1_mem_rd", mr4, 0);
    chk("t1_addr", addr4, 12'hA5C);
    chk("t1_data", data4, 8'h3B);
    chk("t1_ready_wr", b4.slave_ready, 0);
    chk("t1_l0_mem_wr", mw0, 1);
    tick;
    chk("t1_mem_wr_pulse", mw4, 0);
    chk("t1_rx_done_pulse", b4.rx_done, 0);
    chk("t1_ready_idle", b4.slave_ready, 1);
    chk("t1_addr_held", addr4, 12'hA5C);

    // 2: read 0x123, datain 0xC6; zero-latency instance checked alongside
    datain = 8'hC6;
    send(0, 1, 12'h123, 8'h00, -1, 0);
    chk("t2_mem_rd", mr4, 1);
    chk("t2_rx_done", b4.rx_done, 1);
    chk("t2_addr", addr4, 12'h123);
    chk("t2_data_held", data4, 8'h3B);
    chk("t2_split_n1", b4.split_en, 0);
    chk("t5_l0_sv_n1", b0.slave_valid, 0);
    chk("t5_l0_mem_rd", mr0, 1);
    tick;
    chk("t5_l0_sv_n2", b0.slave_valid, 1);
    chk("t5_l0_bit0", b0.tx_data, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_split%0d", k), b4.split_en, 1);
      chk("t2_sv_split", b4.slave_valid, 0);
      chk("t2_mem_rd_pulse", mr4, 0);
      if (k == 0) chk("t5_l0_split", b0.split_en, 0);
      if (k == 1) chk("t5_l0_bit1", b0.tx_data, 1);
      tick;
    end
    chk("t2_split_off", b4.split_en, 0);
    recv("t2", 8'hC6, -1, 0);

    // 3: write 0x7FF with a 3-cycle master_valid stall after bit 5
    t0 = cyc;
    send(1, 0, 12'h7FF, 8'h55, 5, 3);
    chk("t3_latency", cyc - t0, 15);
    chk("t3_mem_wr", mw4, 1);
    chk("t3_addr", addr4, 12'h7FF);
    chk("t3_data", data4, 8'h55);
    tick;

    // 4: read with master_ready low for 2 cycles on bit 3
    datain = 8'hA9;
    send(0, 1, 12'h0F0, 8'h00, -1, 0);
    chk("t4_mem_rd", mr4, 1);
    repeat (5) tick;
    recv("t4", 8'hA9, 3, 2);

    // 5: read_en and write_en together -> write only
    send(1, 1, 12'h456, 8'h9E, -1, 0);
    chk("t5_mem_wr", mw4, 1);
    chk("t5_mem_rd", mr4, 0);
    chk("t5_l0_mem_wr", mw0, 1);
    chk("t5_addr", addr4, 12'h456);
    chk("t5_data", data4, 8'h9E);
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("t5_no_rd", {mr4, mr0, b4.slave_valid, b4.split_en}, 0);
    end

    // 6: reset in the middle of SPLIT, then a normal read
    datain = 8'h5A;
    send(0, 1, 12'h321, 8'h00, -1, 0);
    repeat (2) tick;
    chk("t6_in_split", b4.split_en, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_split", b4.split_en, 0);
    chk("t6_rst_ready", b4.slave_ready, 1);
    chk("t6_rst_sv", {b4.slave_valid, b0.slave_valid}, 0);
    chk("t6_rst_addr", addr4, 0);
    chk("t6_rst_data", data4, 0);
    chk("t6_rst_mem", {mw4, mr4}, 0);
    tick;
    reset = 1'b1;
    tick;
    datain = 8'h3C;
    send(0, 1, 12'h2AB, 8'h00, -1, 0);
    chk("t6_mem_rd", mr4, 1);
    chk("t6_addr", addr4, 12'h2AB);
    repeat (5) tick;
    recv("t6", 8'h3C, -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
